branch_predictor_bht: RTL

//  Dynamic branch predictor. Successor to the CPU's static ID-stage predictor.

---
 rtl/branch_predictor_bht.sv | 107 ++++++++++
 1 files changed

// File: rtl/branch_predictor_bht.sv
// Direct-mapped, tagged branch history table with saturating counters and a target buffer.
// Lookups read the registered table combinationally; EX-stage updates commit on the next rising edge.
module branch_predictor_bht #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    // No backpressure on either side: a *_valid cycle is consumed at the next edge, unconditionally.
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_valid,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_pred_taken,
    input  logic [ADDR_W-1:0] update_pred_tgt,
    input  logic              table_clear,
    output logic              mispredict,
    output logic [31:0]       stat_lookups,
    output logic [31:0]       stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN = '0;
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q [ENTRIES];
    logic [ADDR_W-1:0]   tgt_q [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0] up_tag;
    logic                up_hit;
    logic                mis_cond;
    logic                unused_pc_bits;

    assign lk_idx = lookup_pc[IDX_BITS+1:2];
    assign lk_tag = lookup_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign up_idx = update_pc[IDX_BITS+1:2];
    assign up_tag = update_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    // Only the index and tag fields of the update PC select an entry.
    assign unused_pc_bits = &{1'b0, update_pc[ADDR_W-1:IDX_BITS+TAG_BITS+2], update_pc[1:0]};

    always_comb begin
        pred_hit    = lookup_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit & ctr_q[lk_idx][CTR_BITS-1];
        pred_target = pred_taken ? tgt_q[lk_idx] : (lookup_pc + ADDR_W'(4));
    end

    always_comb begin
        up_hit   = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
        mis_cond = update_valid &
                   ((update_pred_taken != update_taken) |
                    (update_taken & (update_pred_tgt != update_target)));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                ctr_q[i] <= CTR_WNT;
                tgt_q[i] <= '0;
            end
            mispredict       <= 1'b0;
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            mispredict       <= mis_cond;
            stat_lookups     <= stat_lookups + 32'(lookup_valid);
            stat_mispredicts <= stat_mispredicts + 32'(mis_cond);
            // A clear drops any same-cycle update; counters and targets survive it.
            if (table_clear) begin
                valid_q <= '0;
            end else if (update_valid) begin
                if (up_hit) begin
                    if (update_taken) begin
                        if (ctr_q[up_idx] != CTR_MAX) begin
                            ctr_q[up_idx] <= ctr_q[up_idx] + CTR_BITS'(1);
                        end
                        tgt_q[up_idx] <= update_target;
                    end else if (ctr_q[up_idx] != CTR_MIN) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] - CTR_BITS'(1);
                    end
                end else if (update_taken) begin
                    valid_q[up_idx] <= 1'b1;
                    tag_q[up_idx]   <= up_tag;
                    ctr_q[up_idx]   <= CTR_WT;
                    tgt_q[up_idx]   <= update_target;
                end
            end
        end
    end

endmodule
